keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of matrix rows sensed; legal range 2..8.
REQ-002 Parameter COLS, default 4: number of matrix columns driven; legal range 2..8.
REQ-003 Parameter SCAN_DIV, default 1000: clocks per column dwell; minimum 4.
REQ-004 Parameter DEBOUNCE, default 4: consecutive identical samples needed to accept a press or release; minimum 1.
REQ-005 Derived KW = clog2(ROWS*COLS), minimum 1: key code width.
REQ-006 Clock, asynchronous reset and ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low.
- row  input  ROWS  matrix rows, active-low, asynchronous to clk.
- shift_col  output  COLS  column drive, active-low; exactly one bit low at all times.
- key_code  output  KW  code of the last accepted key = col_index*ROWS + row_index.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from the key_valid cycle until the release is accepted.
- key_release  output  1  one-cycle pulse when a release is accepted.
- multi_key  output  1  high while the latest sample shows two or more rows low.

Function
REQ-007 row SHALL pass through a 2-flop synchroniser before any use.
REQ-008 A dwell timer SHALL count 0..SCAN_DIV-1 and issue a sample tick on count SCAN_DIV-1, wrapping to 0.
REQ-009 The rows SHALL be sampled only on sample ticks; the sampled value is the synchronised row.
REQ-010 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-011 SCAN: tick with all rows high -> rotate shift_col one column; col COLS-1 wraps to 0.
REQ-012 SCAN: tick with exactly one row low -> capture col/row index, freeze column, count=1, go DEBOUNCE.
REQ-012a If DEBOUNCE=1, the REQ-012 tick SHALL instead accept the press immediately as in REQ-014.
REQ-013 DEBOUNCE: tick with same pattern -> count+1; different pattern -> go SCAN and rotate to next column on that tick.
REQ-014 DEBOUNCE: count reaching DEBOUNCE -> key_code updated, key_valid pulsed that cycle, key_held=1, go HELD.
REQ-015 HELD: column stays frozen; tick with all rows high -> count=1, go RELEASE; otherwise stay.
REQ-016 RELEASE: tick with any row low -> return to HELD; all-high count reaching DEBOUNCE -> key_release pulse, key_held=0, go SCAN and rotate to next column.
REQ-017 multi_key SHALL be updated on every tick in every state; multi-row samples never trigger a capture. In DEBOUNCE they count as a different pattern.
REQ-018 key_code SHALL hold its value until the next accepted press; it does not clear on release.
REQ-019 key_valid and key_release SHALL never both be high in the same cycle and never be high longer than one cycle.
REQ-020 Debounce counter width clog2(DEBOUNCE+1); it saturates and never wraps.

Reset
REQ-021 On reset low, immediately and independent of clk: shift_col = column 0 low, others high; key_code=0; key_valid, key_held, key_release, multi_key = 0; state=SCAN; timer, counter and synchroniser = reset values (synchroniser = all-ones).
REQ-022 Reset asserted in any state, including mid-DEBOUNCE or HELD, SHALL abort without emitting key_valid or key_release.
REQ-023 After reset deasserts, the first tick SHALL occur SCAN_DIV clocks later.

Structure
REQ-024 Package keypad_pkg SHALL hold the state enum and a clog2 helper function.
REQ-025 Dwell timer SHALL be a sub-module keypad_scan_timer (parameter SCAN_DIV, output tick).

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3)
REQ-026 Reset pulse mid-run -> shift_col=4'b1110, all outputs 0 immediately; first tick 8 clocks after release.
REQ-027 row=4'b1101 while shift_col=4'b1011, stable -> key_code=9 on the third tick after capture, key_valid exactly one cycle, key_held=1, shift_col frozen at 4'b1011.
REQ-028 Same press removed after one tick (bounce) -> no key_valid; shift_col=4'b0111 on that tick.
REQ-029 From HELD, rows 4'b1111 for 3 ticks -> key_release one cycle, key_held=0, shift_col=4'b0111; 1111,1111,1101 -> back to HELD, no pulse.
REQ-030 row=4'b1001 in any column -> multi_key=1, no capture, scanning continues; single/no key sample -> multi_key=0.
REQ-031 Full sweep: press each of the 16 keys in turn -> key_code 0..15 in order, one key_valid and one key_release each.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int kp_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column dwell timer: counts 0..SCAN_DIV-1 and flags the last count as the sample tick.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = kp_clog2(SCAN_DIV);
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

  logic [TW-1:0] count;

  // Free-running dwell count, wraps to zero after the tick count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else if (count == LAST) count <= '0;
    else count <= count + TW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: drives one column low at a time, samples the rows
// once per dwell, debounces press and release and reports the key code.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SCAN     | rotating columns, waiting for exactly one row low
// ST_DEBOUNCE | column frozen, counting identical samples of the candidate
// ST_HELD     | press accepted, column frozen, waiting for all rows high
// ST_RELEASE  | counting consecutive all-high samples before reporting release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int KW      = kp_clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] shift_col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            key_release,
  output logic            multi_key
);

  localparam int CW = kp_clog2(COLS);
  localparam int RW = kp_clog2(ROWS);
  localparam int DW = kp_clog2(DEBOUNCE + 1);

  logic [ROWS-1:0] row_meta, row_s;
  logic            tick;

  kp_state_t       state, state_nxt;
  logic [CW-1:0]   col_idx, col_nxt, col_rot;
  logic [DW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            deb_done;
  logic [ROWS-1:0] pattern, pattern_nxt;
  logic [KW-1:0]   code_q, code_nxt, code_new;
  logic            valid_q, valid_nxt;
  logic            release_q, release_nxt;
  logic            multi_q, multi_nxt;

  logic [3:0]      n_low;
  logic [RW-1:0]   low_idx;
  logic            all_high, one_low, multi;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous row inputs; idle level is all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= '1;
      row_s    <= '1;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // Classify the synchronised rows: how many are low and which one.
  always_comb begin
    n_low   = 4'd0;
    low_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!row_s[i]) begin
        n_low   = n_low + 4'd1;
        low_idx = RW'(i);
      end
    end
  end

  assign all_high = (n_low == 4'd0);
  assign one_low  = (n_low == 4'd1);
  assign multi    = (n_low >= 4'd2);

  assign col_rot  = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
  // Saturating increment so the counter can never wrap back below DEBOUNCE.
  assign cnt_inc  = (cnt == DW'(DEBOUNCE)) ? cnt : cnt + DW'(1);
  assign deb_done = (cnt_inc == DW'(DEBOUNCE));
  assign code_new = KW'(int'(col_idx) * ROWS + int'(low_idx));

  // State and datapath registers; pulses are registered so they last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      col_idx   <= '0;
      cnt       <= '0;
      pattern   <= '1;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      cnt       <= cnt_nxt;
      pattern   <= pattern_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
      release_q <= release_nxt;
      multi_q   <= multi_nxt;
    end
  end

  // Next-state logic; everything advances only on a sample tick.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    code_nxt    = code_q;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    multi_nxt   = multi_q;
    if (tick) begin
      multi_nxt = multi;
      case (state)
        ST_SCAN: begin
          if (one_low) begin
            pattern_nxt = row_s;
            cnt_nxt     = DW'(1);
            if (DEBOUNCE == 1) begin
              code_nxt  = code_new;
              valid_nxt = 1'b1;
              state_nxt = ST_HELD;
            end else begin
              state_nxt = ST_DEBOUNCE;
            end
          end else begin
            // Idle or multi-key samples keep the scan moving.
            col_nxt = col_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == pattern) begin
            cnt_nxt = cnt_inc;
            if (deb_done) begin
              code_nxt  = code_new;
              valid_nxt = 1'b1;
              state_nxt = ST_HELD;
            end
          end else begin
            state_nxt = ST_SCAN;
            col_nxt   = col_rot;
          end
        end
        ST_HELD: begin
          if (all_high) begin
            cnt_nxt = DW'(1);
            if (DEBOUNCE == 1) begin
              release_nxt = 1'b1;
              state_nxt   = ST_SCAN;
              col_nxt     = col_rot;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (!all_high) begin
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt_inc;
            if (deb_done) begin
              release_nxt = 1'b1;
              state_nxt   = ST_SCAN;
              col_nxt     = col_rot;
            end
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  // Output decode from registered state: one active-low column, held flag, pulses.
  always_comb begin
    shift_col = '1;
    for (int c = 0; c < COLS; c++) shift_col[c] = (int'(col_idx) != c);
    key_held    = (state == ST_HELD) || (state == ST_RELEASE);
    key_code    = code_q;
    key_valid   = valid_q;
    key_release = release_q;
    multi_key   = multi_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed bench for keypad_scanner against a tick-level reference model.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] shift_col;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_key;

  int total = 0;
  int bad   = 0;

  // reference model, one step per sample tick
  int         m_col, m_cnt, m_rel, m_code;
  bit         m_held, m_multi, e_valid, e_rel;
  logic [3:0] m_cand;
  int         n_valid, n_rel;
  int         codes[$];

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .shift_col   (shift_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_shift(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic model_reset();
    m_col = 0; m_cnt = 0; m_rel = 0; m_code = 0;
    m_held = 0; m_multi = 0; e_valid = 0; e_rel = 0; m_cand = 4'hF;
  endtask

  task automatic model_step(input logic [3:0] r);
    int lows, idx;
    lows = 0; idx = 0;
    for (int i = 0; i < ROWS; i++) if (!r[i]) begin lows++; idx = i; end
    e_valid = 0; e_rel = 0;
    m_multi = (lows >= 2);
    if (!m_held) begin
      if (m_cnt == 0) begin
        if (lows == 1) begin
          m_cand = r;
          m_cnt = 1;
        end else begin
          m_col = (m_col + 1) % COLS;
        end
      end else if (r == m_cand) begin
        m_cnt++;
      end else begin
        m_cnt = 0;
        m_col = (m_col + 1) % COLS;
      end
      if (m_cnt >= DEB) begin
        m_code = m_col * ROWS + idx;
        m_held = 1; e_valid = 1; m_cnt = 0; m_rel = 0;
      end
    end else if (lows == 0) begin
      m_rel++;
      if (m_rel >= DEB) begin
        m_held = 0; m_rel = 0; e_rel = 1;
        m_col = (m_col + 1) % COLS;
      end
    end else begin
      m_rel = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("shift_col", shift_col, exp_shift(m_col));
    check_val("key_code", key_code, m_code);
    check_val("key_valid", key_valid, e_valid);
    check_val("key_held", key_held, m_held);
    check_val("key_release", key_release, e_rel);
    check_val("multi_key", multi_key, m_multi);
  endtask

  // One full dwell: drive the rows, check pulses dropped, no early tick, then the tick result.
  task automatic tick_step(input logic [3:0] r);
    row = r;
    @(posedge clk); #1;
    check_val("valid_one_cycle", key_valid, 0);
    check_val("release_one_cycle", key_release, 0);
    repeat (SCAN_DIV - 2) @(posedge clk);
    #1;
    check_val("no_early_tick", shift_col, exp_shift(m_col));
    @(posedge clk); #1;
    model_step(r);
    check_outputs();
    check_val("pulses_exclusive", key_valid & key_release, 0);
    if (key_valid) begin n_valid++; codes.push_back(int'(key_code)); end
    if (key_release) n_rel++;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_val("rst_shift_col", shift_col, 4'b1110);
    check_val("rst_key_code", key_code, 0);
    check_val("rst_flags", {key_valid, key_held, key_release, multi_key}, 4'b0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic goto_col(input int c);
    for (int i = 0; i < COLS + 1; i++) if (m_col != c) tick_step(4'hF);
  endtask

  initial begin
    int nv0, nr0, len;
    logic [3:0] pat;
    n_valid = 0; n_rel = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // first tick lands SCAN_DIV clocks after reset release
    tick_step(4'hF);
    check_val("first_tick_col", shift_col, 4'b1101);

    // stable press at column 2 row 1, then partial and full release
    goto_col(2);
    nv0 = n_valid;
    tick_step(4'b1101);
    tick_step(4'b1101);
    tick_step(4'b1101);
    check_val("press_code", key_code, 9);
    check_val("press_pulse", key_valid, 1);
    check_val("press_frozen_col", shift_col, 4'b1011);
    tick_step(4'hF);
    tick_step(4'hF);
    tick_step(4'b1101);
    check_val("rehold_held", key_held, 1);
    check_val("rehold_no_release", key_release, 0);
    tick_step(4'hF);
    tick_step(4'hF);
    tick_step(4'hF);
    check_val("release_pulse", key_release, 1);
    check_val("release_col", shift_col, 4'b0111);
    check_val("release_held", key_held, 0);
    check_val("one_valid", n_valid - nv0, 1);

    // bounce: removed after a single tick
    goto_col(2);
    nv0 = n_valid;
    tick_step(4'b1101);
    tick_step(4'hF);
    check_val("bounce_col", shift_col, 4'b0111);
    check_val("bounce_no_valid", n_valid - nv0, 0);

    // two rows low: flagged, never captured
    tick_step(4'b1001);
    check_val("multi_set", multi_key, 1);
    check_val("multi_rotates", shift_col, 4'b1110);
    tick_step(4'hF);
    check_val("multi_clear", multi_key, 0);

    // reset mid-debounce aborts silently
    goto_col(1);
    nv0 = n_valid;
    tick_step(4'b1110);
    tick_step(4'b1110);
    do_reset();
    tick_step(4'b1110);
    tick_step(4'hF);
    check_val("abort_no_valid", n_valid - nv0, 0);

    // full sweep of all sixteen keys
    codes.delete();
    nv0 = n_valid; nr0 = n_rel;
    for (int k = 0; k < ROWS * COLS; k++) begin
      goto_col(k / ROWS);
      pat = 4'hF;
      pat[k % ROWS] = 1'b0;
      for (int t = 0; t < DEB; t++) tick_step(pat);
      for (int t = 0; t < DEB; t++) tick_step(4'hF);
    end
    check_val("sweep_valids", n_valid - nv0, ROWS * COLS);
    check_val("sweep_releases", n_rel - nr0, ROWS * COLS);
    check_val("sweep_code_count", codes.size(), ROWS * COLS);
    for (int k = 0; k < codes.size() && k < ROWS * COLS; k++)
      check_val("sweep_code", codes[k], k);

    // randomised segments of idle, single keys and arbitrary patterns
    for (int n = 0; n < 250; n += len) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: pat = 4'hF;
        4, 5, 6, 7: begin pat = 4'hF; pat[$urandom_range(0, 3)] = 1'b0; end
        default:    pat = 4'($urandom_range(0, 15));
      endcase
      len = int'($urandom_range(1, 5));
      for (int t = 0; t < len; t++) tick_step(pat);
      if (n >= 120 && n < 120 + len) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
